// File: rtl/gpr_xfer_ctrl.sv
// Register-transfer sequencer for a bank of NREG GPRs sharing one W-bit bus.
// Each command runs IDLE -> DRIVE -> WRITE -> DONE with every strobe registered.
module gpr_xfer_ctrl #(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned SELW = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SELW-1:0] cmd_src,
  input  logic [SELW-1:0] cmd_dst,
  input  logic [W-1:0]    cmd_data,
  output logic            ext_oe,
  output logic [W-1:0]    ext_data,
  output logic [NREG-1:0] oa,
  output logic [NREG-1:0] wa,
  input  logic [W-1:0]    bus_in,
  output logic [W-1:0]    rd_data,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, DONE} state_e;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_MOVE = 2'b10,
    OP_READ = 2'b11
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [SELW-1:0] src_q, src_d;
  logic [SELW-1:0] dst_q, dst_d;
  logic            ill_q, ill_d;

  logic            cmd_ready_q, cmd_ready_d;
  logic            ext_oe_q, ext_oe_d;
  logic [W-1:0]    ext_data_q, ext_data_d;
  logic [NREG-1:0] oa_q, oa_d;
  logic [NREG-1:0] wa_q, wa_d;
  logic [W-1:0]    rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            cmd_illegal;
  logic            src_en;

  function automatic logic idx_ok(input logic [SELW-1:0] idx);
    return ({{(32-SELW){1'b0}}, idx} < NREG);
  endfunction

  // Only the indices an op actually uses are range-checked.
  always_comb begin
    cmd_illegal = 1'b0;
    case (op_e'(cmd_op))
      OP_NOP:  cmd_illegal = 1'b0;
      OP_LOAD: cmd_illegal = !idx_ok(cmd_dst);
      OP_MOVE: cmd_illegal = !idx_ok(cmd_src) || !idx_ok(cmd_dst) || (cmd_src == cmd_dst);
      OP_READ: cmd_illegal = !idx_ok(cmd_src);
      default: cmd_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    ill_d      = ill_q;
    ext_data_d = ext_data_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = op_e'(cmd_op);
          src_d      = cmd_src;
          dst_d      = cmd_dst;
          ill_d      = cmd_illegal;
          ext_data_d = cmd_data;
          state_d    = (op_d == OP_NOP || cmd_illegal) ? DONE : DRIVE;
        end
      end
      DRIVE: state_d = WRITE;
      WRITE: begin
        if (op_q == OP_READ) rd_data_d = bus_in;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they appear registered,
    // aligned with the state they belong to.
    src_en      = (state_d == DRIVE) || (state_d == WRITE);
    ext_oe_d    = src_en && (op_d == OP_LOAD);
    oa_d        = (src_en && (op_d == OP_MOVE || op_d == OP_READ))
                  ? (NREG'(1) << src_d) : '0;
    wa_d        = ((state_d == WRITE) && (op_d == OP_LOAD || op_d == OP_MOVE))
                  ? (NREG'(1) << dst_d) : '0;
    done_d      = (state_d == DONE);
    err_d       = done_d && ill_d;
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      src_q       <= '0;
      dst_q       <= '0;
      ill_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      ext_oe_q    <= 1'b0;
      ext_data_q  <= '0;
      oa_q        <= '0;
      wa_q        <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      ill_q       <= ill_d;
      cmd_ready_q <= cmd_ready_d;
      ext_oe_q    <= ext_oe_d;
      ext_data_q  <= ext_data_d;
      oa_q        <= oa_d;
      wa_q        <= wa_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign ext_oe    = ext_oe_q;
  assign ext_data  = ext_data_q;
  assign oa        = oa_q;
  assign wa        = wa_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
